event_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the single event output channel between `NUM_REQ` pixel requesters. Each requester presents a 2-bit polarity request: `2'b10` is ON and `2'b01` is OFF. The block picks one requester, emits its address and polarity over a valid/ready channel, then returns a one-cycle grant so the pixel can clear its request. It sits between the pixel request array and the event output encoder/FIFO, replacing direct per-pixel polarity decoding.

---
 rtl/event_rr_scheduler.sv | 119 +++++++++++
 tb/tb_event_rr_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_rr_scheduler.sv
// Round-robin arbiter that shares one valid/ready event channel between NUM_REQ
// polarity requesters. Each served requester gets a one-cycle grant so it can drop its request.
module event_rr_scheduler #(
  parameter int NUM_REQ  = 16,
  parameter int POLARITY = 2,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int CNT_W    = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ*POLARITY-1:0]  req_i,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [IDX_W-1:0]             evt_addr_o,
  output logic                         evt_pol_o,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic                         busy_o,
  output logic [CNT_W-1:0]             evt_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, GRANT} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [1:0]           pend_q;
  logic                 valid_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [NUM_REQ-1:0]   active;
  logic                 found;
  logic [IDX_W-1:0]     sel_idx;
  logic [1:0]           sel_pend;
  int                   pos;

  always_comb begin
    active = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      active[n] = |req_i[n*POLARITY +: POLARITY];
    end
  end

  // Circular search starting at ptr_q; the first active index wins.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_pend = '0;
    pos      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr_q) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && active[pos]) begin
        found    = 1'b1;
        sel_idx  = IDX_W'(pos);
        sel_pend = req_i[pos*POLARITY +: 2];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            idx_q   <= sel_idx;
            pend_q  <= sel_pend;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (evt_ready_i) begin
            cnt_q <= cnt_q + 1'b1;
            // A dual request sends ON first, then OFF for the same address.
            if (pend_q == 2'b11) begin
              pend_q[1] <= 1'b0;
            end else begin
              valid_q <= 1'b0;
              gnt_q   <= NUM_REQ'(1) << idx_q;
              state_q <= GRANT;
            end
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_addr_o  = idx_q;
  assign evt_pol_o   = pend_q[1];
  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;
  assign evt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_event_rr_scheduler.sv
// Scoreboard bench for event_rr_scheduler: a transaction-level round-robin model
// queues expected events/grants, a negedge monitor compares what the DUT presents.
module tb_event_rr_scheduler;
  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2*N-1:0] req = '0;
  logic          ready = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_addr;
  logic          evt_pol;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [CW-1:0] evt_cnt;

  always #5 clk = ~clk;

  event_rr_scheduler #(.NUM_REQ(N), .POLARITY(2), .IDX_W(2), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req),
    .evt_valid_o(evt_valid), .evt_ready_i(ready),
    .evt_addr_o(evt_addr), .evt_pol_o(evt_pol),
    .gnt_o(gnt), .busy_o(busy), .evt_cnt_o(evt_cnt)
  );

  typedef struct packed {logic [1:0] addr; logic pol;} evt_t;
  evt_t       exp_evt[$];
  logic [1:0] exp_gnt[$];
  int         m_ptr = 0;
  logic [CW-1:0] m_cnt = '0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req_v);
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h, required nothing (queue empty)", name, act);
  endtask

  // Requests only drop once granted, so a fixed set is served once each in circular order from the pointer.
  task automatic model_serve(input logic [2*N-1:0] rv);
    int last;
    logic [1:0] f;
    last = -1;
    for (int i = 0; i < N; i++) begin
      int n;
      n = (m_ptr + i) % N;
      f = rv[2*n +: 2];
      if (f != 2'b00) begin
        if (f[1]) begin exp_evt.push_back('{2'(n), 1'b1}); m_cnt = m_cnt + 1'b1; end
        if (f[0]) begin exp_evt.push_back('{2'(n), 1'b0}); m_cnt = m_cnt + 1'b1; end
        exp_gnt.push_back(2'(n));
        last = n;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N;
  endtask

  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) if (gnt[n]) req[2*n +: 2] = 2'b00;
    ready = rdy;
  endtask

  task automatic drain(input int pct, input string tag);
    int cyc;
    cyc = 0;
    while ((exp_evt.size() != 0 || exp_gnt.size() != 0 || busy) && cyc < 300) begin
      step(1'($urandom_range(99) < pct));
      cyc++;
    end
    chk({tag, " drained"}, 32'(exp_evt.size() + exp_gnt.size()), 32'd0);
    chk({tag, " cnt"}, 32'(evt_cnt), 32'(m_cnt));
  endtask

  // Monitor
  initial begin
    evt_t e;
    logic [1:0] g;
    logic pv, pr, pp;
    logic [1:0] pa;
    logic [CW-1:0] ec;
    pv = 1'b0; pr = 1'b0; pp = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 1'b0;
      end else begin
        if (evt_valid && pv && !pr) begin
          chk("hold addr", 32'(evt_addr), 32'(pa));
          chk("hold pol", 32'(evt_pol), 32'(pp));
        end
        if (gnt != '0) begin
          chk("gnt while valid", 32'(evt_valid), 32'd0);
          if (exp_gnt.size() == 0) fail_unexp("unexpected gnt", 32'(gnt));
          else begin
            g = exp_gnt.pop_front();
            chk("gnt", 32'(gnt), 32'(4'b0001 << g));
          end
        end
        if (evt_valid && ready) begin
          if (exp_evt.size() == 0) fail_unexp("unexpected evt", {29'd0, evt_addr, evt_pol});
          else begin
            ec = m_cnt - CW'(exp_evt.size());
            chk("evt cnt", 32'(evt_cnt), 32'(ec));
            e = exp_evt.pop_front();
            chk("evt addr", 32'(evt_addr), 32'(e.addr));
            chk("evt pol", 32'(evt_pol), 32'(e.pol));
          end
        end
        pv = evt_valid; pr = ready; pa = evt_addr; pp = evt_pol;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values with random requests
    req = 8'($urandom);
    ready = 1'b1;
    repeat (3) step(1'b1);
    chk("reset outs", {15'd0, evt_valid, gnt, busy, evt_cnt, evt_addr, evt_pol}, 32'd0);
    req = 8'($urandom) | 8'h01;
    step(1'b1);
    chk("reset outs2", {15'd0, evt_valid, gnt, busy, evt_cnt, evt_addr, evt_pol}, 32'd0);
    req = '0;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) step(1'b1);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle valid", 32'(evt_valid), 32'd0);

    // Single request on requester 2
    req = 8'b00_10_00_00;
    model_serve(req);
    step(1'b1);
    chk("single evt", {28'd0, evt_valid, evt_addr, evt_pol}, {28'd0, 4'b1_10_1});
    step(1'b1);
    chk("single gnt", {27'd0, evt_valid, gnt}, {27'd0, 5'b0_0100});
    step(1'b1);
    chk("single after gnt", {27'd0, busy, gnt}, 32'd0);
    drain(100, "single");

    // Fairness between requesters 0 and 3
    repeat (2) begin
      req = 8'b01_00_00_01;
      model_serve(req);
      drain(100, "rr");
    end

    // Dual polarity on requester 1
    req = 8'b00_00_11_00;
    model_serve(req);
    step(1'b1);
    chk("dual on", {28'd0, evt_valid, evt_addr, evt_pol}, {28'd0, 4'b1_01_1});
    step(1'b1);
    chk("dual off", {28'd0, evt_valid, evt_addr, evt_pol}, {28'd0, 4'b1_01_0});
    step(1'b1);
    chk("dual gnt", {27'd0, evt_valid, gnt}, {27'd0, 5'b0_0010});
    drain(100, "dual");

    // Backpressure on requester 3 while requester 0 arrives
    req = 8'b10_00_00_00;
    model_serve(req);
    step(1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      chk("bp evt", {28'd0, evt_valid, evt_addr, evt_pol}, {28'd0, 4'b1_11_1});
      chk("bp gnt", 32'(gnt), 32'd0);
      if (c == 1) begin
        req[1:0] = 2'b01;
        model_serve(8'b00_00_00_01);
      end
    end
    drain(100, "bp");

    // Random request sets and ready throttling
    for (int t = 0; t < 40; t++) begin
      logic [2*N-1:0] rv;
      rv = 8'($urandom);
      req = rv;
      model_serve(rv);
      drain(int'($urandom_range(100, 30)), "rand");
    end

    // Leave the pointer at 3, then reset in the middle of a stalled send
    req = 8'b00_10_00_00;
    model_serve(req);
    drain(100, "pre");
    req = 8'b10_00_00_00;
    step(1'b0);
    step(1'b0);
    chk("pre-reset valid", 32'(evt_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async reset outs", {15'd0, evt_valid, gnt, busy, evt_cnt, evt_addr, evt_pol}, 32'd0);
    exp_evt.delete();
    exp_gnt.delete();
    m_ptr = 0;
    m_cnt = '0;
    req[5:4] = 2'b01;
    step(1'b1);
    step(1'b1);
    chk("in reset gnt", {27'd0, busy, gnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_serve(req);
    drain(100, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
